// File: rtl/uart_pkg.sv
// Shared types and constant helpers for the UART receiver.
// UART_RX_PARITY_EN adds the PARITY state and the parity flag of a FIFO entry.
package uart_pkg;

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif

    // Flag half of a FIFO entry; the data word is appended below it at its configured width.
    typedef struct packed {
`ifdef UART_RX_PARITY_EN
        logic parity_err;
`endif
        logic frame_err;
    } rx_entry_t;

    function automatic int tick_period(input int sys_clk, input int baud, input int oversample);
        return (sys_clk / baud) / oversample;
    endfunction

    function automatic int cnt_width(input int num_values);
        return (num_values < 2) ? 1 : $clog2(num_values);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Consumer handshake of the UART receiver: show-ahead head entry with valid/ready.
interface uart_rx_if #(
    parameter int WORD_WIDTH = 8
);
    logic [WORD_WIDTH-1:0] o_data;
    logic                  o_parity_err;
    logic                  o_frame_err;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output o_data,
        output o_parity_err,
        output o_frame_err,
        output o_valid,
        input  i_ready
    );

    modport slave (
        input  o_data,
        input  o_parity_err,
        input  o_frame_err,
        input  o_valid,
        output i_ready
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO with a one-cycle overrun pulse; DEPTH is a power of two, at least 2.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             valid,
    output logic             overrun
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] ptr_t;

    logic [WIDTH-1:0] mem [DEPTH];
    ptr_t             wr_ptr_reg;
    ptr_t             rd_ptr_reg;
    logic             overrun_reg;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            overrun_reg <= 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + ptr_t'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + ptr_t'(1);
            end
            overrun_reg <= push && !do_push;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data;
        end
    end

    assign head    = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];
    assign valid   = !empty;
    assign overrun = overrun_reg;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: synchronized line, oversampled start/data/stop FSM feeding a show-ahead FIFO.
// Define UART_RX_PARITY_EN to receive and check a parity bit between data and stop.
module uart_rx
    import uart_pkg::*;
#(
    parameter int G_SYS_CLK     = 40000000,
    parameter int G_BAUD        = 256000,
    parameter int G_OVERSAMPLE  = 16,
    parameter int G_WORD_WIDTH  = 8,
    parameter bit G_PARITY_TYPE = 1'b1,
    parameter int G_FIFO_DEPTH  = 4
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_rx,
    uart_rx_if.master rx_bus,
    output logic      o_rx_busy,
    output logic      o_overrun
);
    localparam int TICK_PERIOD = tick_period(G_SYS_CLK, G_BAUD, G_OVERSAMPLE);
    localparam int TICK_W      = cnt_width(TICK_PERIOD);
    localparam int SAMP_W      = cnt_width(G_OVERSAMPLE + 2);
    localparam int BIT_W       = cnt_width(G_WORD_WIDTH);
    localparam int ENTRY_W     = $bits(rx_entry_t) + G_WORD_WIDTH;
    localparam logic [SAMP_W-1:0] START_CENTER = SAMP_W'(G_OVERSAMPLE / 2 - 1);
    localparam logic [SAMP_W-1:0] CENTER       = SAMP_W'(G_OVERSAMPLE);

    logic [1:0]              sync_reg;
    logic                    rx_prev_reg;
    logic                    rx;
    logic                    fall;
    logic [TICK_W-1:0]       tick_cnt_reg;
    logic                    tick;
    rx_state_t               state_reg, state_next;
    logic [SAMP_W-1:0]       cnt_reg, cnt_next;
    logic [SAMP_W-1:0]       ticks;
    logic [BIT_W-1:0]        bit_reg, bit_next;
    logic [G_WORD_WIDTH-1:0] shift_reg, shift_next;
    logic [1:0]              samp_reg, samp_next;
    logic                    frame_err_reg, frame_err_next;
`ifdef UART_RX_PARITY_EN
    logic                    parity_err_reg, parity_err_next;
`endif
    logic                    push_reg, push_next;
    logic                    bit_done;
    logic                    bit_val;
    rx_entry_t               push_flags;
    rx_entry_t               head_flags;
    logic [ENTRY_W-1:0]      head;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_reg     <= 2'b11;
            rx_prev_reg  <= 1'b1;
            tick_cnt_reg <= '0;
        end else begin
            sync_reg     <= {sync_reg[0], i_rx};
            rx_prev_reg  <= sync_reg[1];
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
        end
    end

    assign rx   = sync_reg[1];
    assign fall = rx_prev_reg && !rx;
    assign tick = (tick_cnt_reg == TICK_W'(TICK_PERIOD - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= '0;
            bit_reg        <= '0;
            shift_reg      <= '0;
            samp_reg       <= '0;
            frame_err_reg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= 1'b0;
`endif
            push_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            bit_reg        <= bit_next;
            shift_reg      <= shift_next;
            samp_reg       <= samp_next;
            frame_err_reg  <= frame_err_next;
`ifdef UART_RX_PARITY_EN
            parity_err_reg <= parity_err_next;
`endif
            push_reg       <= push_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        bit_next        = bit_reg;
        shift_next      = shift_reg;
        samp_next       = samp_reg;
        frame_err_next  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
        parity_err_next = parity_err_reg;
`endif
        push_next       = 1'b0;
        bit_done        = 1'b0;
        ticks           = cnt_reg + SAMP_W'(1);
        bit_val         = (samp_reg[0] & samp_reg[1]) | (samp_reg[0] & rx) | (samp_reg[1] & rx);

        // Post-start bits count ticks from the previous center; decide at c+1, so restart at 1.
        if (o_rx_busy && tick) begin
            cnt_next = ticks;
            if (ticks == CENTER - SAMP_W'(1)) begin
                samp_next[0] = rx;
            end else if (ticks == CENTER) begin
                samp_next[1] = rx;
            end else if (ticks == CENTER + SAMP_W'(1)) begin
                bit_done = 1'b1;
                cnt_next = SAMP_W'(1);
            end
        end

        case (state_reg)
            IDLE: begin
                if (fall) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (cnt_reg == START_CENTER) begin
                        cnt_next   = '0;
                        bit_next   = '0;
                        state_next = rx ? IDLE : DATA;
                    end else begin
                        cnt_next = ticks;
                    end
                end
            end
            DATA: begin
                if (bit_done) begin
                    shift_next = {bit_val, shift_reg[G_WORD_WIDTH-1:1]};
                    if (bit_reg == BIT_W'(G_WORD_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        bit_next = bit_reg + BIT_W'(1);
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    parity_err_next = (((^shift_reg) ^ bit_val) != G_PARITY_TYPE);
                    state_next      = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_done) begin
                    frame_err_next = !bit_val;
                    push_next      = 1'b1;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_rx_busy = !(state_reg inside {IDLE, START});

    always_comb begin
        push_flags            = '0;
        push_flags.frame_err  = frame_err_reg;
`ifdef UART_RX_PARITY_EN
        push_flags.parity_err = parity_err_reg;
`endif
    end

    uart_rx_fifo #(
        .DEPTH (G_FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .push      (push_reg),
        .push_data ({push_flags, shift_reg}),
        .pop       (rx_bus.i_ready),
        .head      (head),
        .valid     (rx_bus.o_valid),
        .overrun   (o_overrun)
    );

    assign head_flags         = head[ENTRY_W-1:G_WORD_WIDTH];
    assign rx_bus.o_data      = head[G_WORD_WIDTH-1:0];
    assign rx_bus.o_frame_err = head_flags.frame_err;
`ifdef UART_RX_PARITY_EN
    assign rx_bus.o_parity_err = head_flags.parity_err;
`else
    assign rx_bus.o_parity_err = 1'b0;
`endif
endmodule
